// File: rtl/sram_bist_pkg.sv
// Shared constants for the SRAM March C- BIST: state codes, per-element
// descriptors and the fail counter width helper.
package sram_bist_pkg;

    // FSM state codes; march element Mi is encoded as i+1
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_M0   = 3'd1;
    localparam logic [2:0] ST_M1   = 3'd2;
    localparam logic [2:0] ST_M2   = 3'd3;
    localparam logic [2:0] ST_M3   = 3'd4;
    localparam logic [2:0] ST_M4   = 3'd5;
    localparam logic [2:0] ST_M5   = 3'd6;
    localparam logic [2:0] ST_DONE = 3'd7;

    // Element descriptors, indexed directly by state code (IDLE/DONE bits are 0)
    localparam logic [7:0] EL_DOWN      = 8'b0111_0000;  // M3, M4, M5 descend
    localparam logic [7:0] EL_HAS_READ  = 8'b0111_1100;  // M1..M5 read first
    localparam logic [7:0] EL_READ_INV  = 8'b0010_1000;  // M2, M4 expect ~BG
    localparam logic [7:0] EL_HAS_WRITE = 8'b0011_1110;  // M0..M4 write
    localparam logic [7:0] EL_WRITE_INV = 8'b0001_0100;  // M1, M3 write ~BG

    // Wide enough to count one mismatch for every read of a full run (5*d)
    function automatic int unsigned fail_cnt_width(input int unsigned depth);
        return $clog2(5 * depth + 1);
    endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Loadable up/down address counter for the march elements.
module sram_bist_addr_gen #(
    parameter int unsigned d = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               load_down_i,
    input  logic               step_i,
    input  logic               down_i,
    output logic [$clog2(d)-1:0] addr_o,
    output logic               last_c
);

    localparam int unsigned AW = $clog2(d);

    logic [AW-1:0] addr_q;

    // Reload to the element start address, otherwise step in the element direction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
        end else if (load_i) begin
            addr_q <= load_down_i ? AW'(d - 1) : '0;
        end else if (step_i) begin
            addr_q <= down_i ? addr_q - AW'(1) : addr_q + AW'(1);
        end
    end

    assign addr_o = addr_q;
    assign last_c = down_i ? (addr_q == '0) : (addr_q == AW'(d - 1));

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST initiator for one single_port_asyn_read_SRAM instance.
// Optional build macro BIST_STOP_ON_FAIL_EN: stop at the first read mismatch.
module sram_march_bist
    import sram_bist_pkg::*;
#(
    parameter int unsigned   w  = 8,
    parameter int unsigned   d  = 16,
    parameter logic [w-1:0]  BG = {w{1'b0}}
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           pass,
    output logic [fail_cnt_width(d)-1:0]   fail_count,
    output logic [$clog2(d)-1:0]           fail_addr,
    output logic [$clog2(d)-1:0]           ad,
    output logic [w-1:0]                   data_in,
    output logic                           w_en,
    input  logic [w-1:0]                   data_out
);

    localparam int unsigned AW = $clog2(d);
    localparam int unsigned FW = fail_cnt_width(d);

    logic [2:0]    state_q, state_d;
    logic          phase_q, phase_d;      // 1: current op is the write cycle
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [FW-1:0] fail_count_q, fail_count_d;
    logic [AW-1:0] fail_addr_q, fail_addr_d;
    logic [w-1:0]  data_in_q, data_in_d;
    logic          w_en_q, w_en_d;

    logic          ag_load, ag_load_down, ag_step, ag_down, ag_last;
    logic [AW-1:0] ag_addr;
    logic [2:0]    nxt_st;
    logic [w-1:0]  exp_rd, cur_wr, nxt_wr;
    logic          mismatch;

    assign nxt_st  = 3'(state_q + 3'd1);
    assign exp_rd  = EL_READ_INV[state_q]  ? ~BG : BG;
    assign cur_wr  = EL_WRITE_INV[state_q] ? ~BG : BG;
    assign nxt_wr  = EL_WRITE_INV[nxt_st]  ? ~BG : BG;
    assign ag_down = EL_DOWN[state_q];

    sram_bist_addr_gen #(.d(d)) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .load_i      (ag_load),
        .load_down_i (ag_load_down),
        .step_i      (ag_step),
        .down_i      (ag_down),
        .addr_o      (ag_addr),
        .last_c      (ag_last)
    );

    // Next-state: compare the read ending this cycle, then pick the next SRAM op
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        fail_count_d = fail_count_q;
        fail_addr_d  = fail_addr_q;
        data_in_d    = data_in_q;
        w_en_d       = w_en_q;
        ag_load      = 1'b0;
        ag_load_down = 1'b0;
        ag_step      = 1'b0;
        mismatch     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_M0;
                    phase_d      = 1'b1;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    fail_count_d = '0;
                    fail_addr_d  = '0;
                    data_in_d    = BG;
                    w_en_d       = 1'b1;
                    ag_load      = 1'b1;
                end
            end
            default: begin
                if (!phase_q && (data_out != exp_rd)) begin
                    mismatch = 1'b1;
                    if (fail_count_q == '0) fail_addr_d = ag_addr;
                    if (fail_count_q != '1) fail_count_d = fail_count_q + FW'(1);
                end

                if (!phase_q && EL_HAS_WRITE[state_q]) begin
                    // read done, write the same address next
                    phase_d   = 1'b1;
                    w_en_d    = 1'b1;
                    data_in_d = cur_wr;
                end else if (!ag_last) begin
                    ag_step   = 1'b1;
                    phase_d   = !EL_HAS_READ[state_q];
                    w_en_d    = !EL_HAS_READ[state_q];
                    data_in_d = cur_wr;
                end else if (state_q == ST_M5) begin
                    state_d = ST_DONE;
                    phase_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (fail_count_d == '0);
                    w_en_d  = 1'b0;
                end else begin
                    state_d      = nxt_st;
                    ag_load      = 1'b1;
                    ag_load_down = EL_DOWN[nxt_st];
                    phase_d      = !EL_HAS_READ[nxt_st];
                    w_en_d       = !EL_HAS_READ[nxt_st];
                    data_in_d    = nxt_wr;
                end

`ifdef BIST_STOP_ON_FAIL_EN
                if (mismatch) begin
                    state_d = ST_DONE;
                    phase_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = 1'b0;
                    w_en_d  = 1'b0;
                    ag_load = 1'b0;
                    ag_step = 1'b0;
                end
`else
                if (mismatch) begin
                    busy_d = busy_d;
                end
`endif
            end
        endcase
    end

    // State and registered SRAM/status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            phase_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_count_q <= '0;
            fail_addr_q  <= '0;
            data_in_q    <= '0;
            w_en_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_count_q <= fail_count_d;
            fail_addr_q  <= fail_addr_d;
            data_in_q    <= data_in_d;
            w_en_q       <= w_en_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_count = fail_count_q;
    assign fail_addr  = fail_addr_q;
    assign ad         = ag_addr;
    assign data_in    = data_in_q;
    assign w_en       = w_en_q;

endmodule
